axil_char_writer: RTL
=====================

Name: axil_char_writer

Overview:
- Upstream feeder for the UART mock AXI-Lite slave.
- Accepts bytes from a core-side valid/ready stream and buffers them in a small FIFO.
- Issues one AXI-Lite single-beat write per byte to the UART TX data register at UART_BASE + TX_OFFSET.
- Counts error responses; gives the demo SoC a non-blocking console path.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of two, >= 2.
- UART_BASE, 32'h0000_0000, base address of the UART slave.
- TX_OFFSET, 32'h0000_0004, TX data register offset.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- char_valid  input  1  byte offered by the core.
- char_ready  output  1  FIFO can accept; equals ~full.
- char_data  input  8  byte to print.
- axi  AXI_LITE.Master  -  write channels driven; read channels tied idle (ar_valid=0, r_ready=0).
- busy  output  1  FIFO non-empty or FSM not IDLE.
- err_count  output  ERR_W  saturating count of B responses with b_resp != OKAY.

Behaviour:
Reset (async):
- FSM=IDLE; FIFO empty.
- aw_valid=0, w_valid=0, b_ready=0, busy=0, err_count=0, char_ready=1.
- Reset asserted mid-transaction abandons it immediately; the slave is reset by the same rst_n.

Push:
- Occurs on char_valid & char_ready at a posedge.
- When full, char_ready=0 and data is held by the source.
- No push bypass: a byte pushed in cycle N is first visible as FIFO non-empty in cycle N+1.

FSM, one transaction outstanding:
- IDLE:
  - If FIFO non-empty: pop head into tx_byte register, set aw_pend=1 and w_pend=1, go to SEND.
  - A pop and a push in the same cycle are both honoured; the count is unchanged.
- SEND:
  - aw_valid=aw_pend, w_valid=w_pend.
  - aw_pend clears on the aw handshake and w_pend on the w handshake, independently, in either order or the same cycle.
  - When both are cleared (registered), go to WAIT_B.
  - aw_addr, w_data and w_strb stay stable while the corresponding valid is high.
- WAIT_B:
  - b_ready=1.
  - On b handshake: if b_resp != 2'b00, err_count increments, saturating at all-ones. Then go to IDLE.

Channel values:
- aw_addr = UART_BASE + TX_OFFSET, computed at elaboration.
- aw_prot = 3'b000.
- w_data = {zero-extend, tx_byte}.
- w_strb = 4'b0001, i.e. byte lane 0 only.

Latency and throughput:
- Push at cycle 0; pop at cycle 1; aw_valid/w_valid high at cycle 2.
- With the UART mock (always-ready after idle): handshake cycle 2, B cycle 3, IDLE cycle 4.
- Sustained rate is 1 byte per 3 cycles.

Boundaries:
- Back-pressure on aw only or w only must not duplicate or drop the other channel's handshake.
- An unexpected b_valid while not in WAIT_B is ignored (b_ready=0).
- FIFO pointers wrap modulo FIFO_DEPTH using an extra MSB for full/empty.
- busy drops only when the FSM is IDLE and the FIFO is empty.

Decomposition:
- uart_pkg:
  - UART_TX_OFFSET constant.
  - AXI resp codes: OKAY, SLVERR, DECERR.
  - typedef enum logic [1:0] {IDLE, SEND, WAIT_B} char_wr_state_t.
- One sub-module: sync_fifo (params WIDTH, DEPTH).
  - Ports: push, pop, wdata, rdata, full, empty.
  - rdata is combinational from the head.
- The FSM and AXI channel logic stay in axil_char_writer.

Test Plan:
1. Single byte: push 8'h41 with a mock slave attached -> exactly one aw (addr 32'h4), one w (data 32'h41, strb 4'b0001), one B; the mock prints "A"; busy low by cycle 4.
2. Burst: push "Hello\n" back-to-back, FIFO_DEPTH=8 -> 6 writes in order, 3 cycles apart; char_ready never drops; err_count=0.
3. Full FIFO: hold aw_ready=0 and push 10 bytes -> char_ready drops after 8 accepted plus 1 in tx_byte; release -> all 9 delivered in order, none lost or duplicated.
4. Split handshakes: w_ready=1 with aw_ready delayed 3 cycles, then the reverse -> w_valid drops after its handshake while aw_valid is held; exactly one B per byte.
5. Error response: slave returns b_resp=2'b10 for 300 writes -> err_count saturates at 8'hFF; the FSM continues normally.
6. Reset mid-op: assert rst_n=0 while in SEND with 3 bytes queued -> all valids low, FIFO empty, err_count=0 immediately; after release a new push of 8'h42 completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the console feeder and the UART mock slave.
package uart_pkg;

  localparam logic [31:0] UART_TX_OFFSET = 32'h0000_0004;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} char_wr_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_char_writer_if.sv
// AXI-Lite bus bundle shared by the console feeder (master) and the UART slave.
// Every channel transfers on the rising edge where its valid and ready are both
// high; a valid, once raised, is held with stable payload until that edge.
interface AXI_LITE;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  modport Master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport Slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axil_char_writer_sync_fifo.sv
// Single-clock FIFO; read data is the current head, shown combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/axil_char_writer.sv
// Console feeder: buffers core bytes and writes each one to the UART TX data
// register as a single AXI-Lite write, one transaction outstanding at a time.
module axil_char_writer
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] UART_BASE  = 32'h0000_0000,
  parameter logic [31:0] TX_OFFSET  = UART_TX_OFFSET,
  parameter int          ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic [7:0]       char_data,
  AXI_LITE.Master          axi,
  output logic             busy,
  output logic [ERR_W-1:0] err_count,
  output char_wr_state_t   dbg_state
);
  localparam logic [31:0] TX_ADDR = UART_BASE + TX_OFFSET;

  char_wr_state_t   state_q, state_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             aw_pend_q, aw_pend_d;
  logic             w_pend_q, w_pend_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_rdata;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (char_valid),
    .pop   (fifo_pop),
    .wdata (char_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          tx_byte_d = fifo_rdata;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        // The two address/data channels retire independently; leave once both are done.
        aw_pend_d = aw_pend_q && !axi.aw_ready;
        w_pend_d  = w_pend_q && !axi.w_ready;
        if (!aw_pend_d && !w_pend_d) state_d = WAIT_B;
      end
      WAIT_B: begin
        if (axi.b_valid) begin
          if (resp_is_err(axi.b_resp) && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_byte_q <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      err_q     <= err_d;
    end
  end

  assign char_ready   = !fifo_full;
  assign busy         = (state_q != IDLE) || !fifo_empty;
  assign err_count    = err_q;
  assign dbg_state    = state_q;

  assign axi.aw_valid = (state_q == SEND) && aw_pend_q;
  assign axi.aw_addr  = TX_ADDR;
  assign axi.aw_prot  = 3'b000;
  assign axi.w_valid  = (state_q == SEND) && w_pend_q;
  assign axi.w_data   = {24'h0, tx_byte_q};
  assign axi.w_strb   = 4'b0001;
  assign axi.b_ready  = (state_q == WAIT_B);

  // Console path is write-only.
  assign axi.ar_valid = 1'b0;
  assign axi.ar_addr  = '0;
  assign axi.ar_prot  = 3'b000;
  assign axi.r_ready  = 1'b0;

  logic unused_rd;
  assign unused_rd = ^{axi.ar_ready, axi.r_valid, axi.r_data, axi.r_resp};

endmodule
